// File: rtl/sync_fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package sync_fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_wr_arbiter_rr_pick.sv
// Round-robin selector: first set bit of req strictly after the one-hot last, wrapping.
// Purely combinational, no backpressure.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] last,
  output logic [NUM_REQ-1:0] pick,
  output logic               any
);

  localparam int IW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  logic [IW-1:0] last_idx;
  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    pick     = '0;
    last_idx = '0;
    idx      = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (last[i]) last_idx = IW'(i);
    end
    // Scan starts one past the previous owner so it is served last.
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = IW'((int'(last_idx) + off) % NUM_REQ);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/sync_fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port; grant 1 cycle after request, one bubble per release.
// fifo_full combinationally drops req_ready and stalls with the grant held.
module sync_fifo_wr_arbiter
  import sync_fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int LOCK_PKT   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy
);

  localparam int CW = clog2(MAX_BURST + 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] last_q, last_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0] pick;
  logic               any;
  logic               xfer;
  logic               last_xfer;
  logic               burst_end;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req  (req_valid),
    .last (last_q),
    .pick (pick),
    .any  (any)
  );

  assign req_ready  = (state_q == ARB_GRANT && !fifo_full) ? grant_q : '0;
  assign xfer       = |(req_valid & req_ready);
  assign last_xfer  = |(req_valid & req_ready & req_last);
  // The transfer that brings the count to MAX_BURST closes the burst.
  assign burst_end  = (LOCK_PKT == 0) && (cnt_q == CW'(MAX_BURST - 1));
  assign fifo_wr_en = xfer;
  assign grant      = grant_q;
  assign busy       = (state_q == ARB_GRANT);

  always_comb begin
    fifo_wr_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) fifo_wr_data = fifo_wr_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (any && !fifo_full) begin
          grant_d = pick;
          cnt_d   = '0;
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (xfer) begin
          if (cnt_q != CW'(MAX_BURST)) cnt_d = cnt_q + 1'b1;
          if (last_xfer || burst_end) begin
            last_d  = grant_q;
            grant_d = '0;
            state_d = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= NUM_REQ'(1) << (NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// Directed bench: packet-locked instance for most steps, burst-split instance for the MAX_BURST step.
module tb_sync_fifo_wr_arbiter;

  logic        clk;
  logic        rst_n;

  logic [3:0]  req_valid, req_last, req_ready, grant;
  logic [31:0] req_data;
  logic        fifo_full, fifo_wr_en, busy;
  logic [7:0]  fifo_wr_data;

  logic [3:0]  req_valid_b, req_last_b, req_ready_b, grant_b;
  logic [31:0] req_data_b;
  logic        fifo_full_b, fifo_wr_en_b, busy_b;
  logic [7:0]  fifo_wr_data_b;

  int total = 0;
  int bad   = 0;

  logic [3:0] exp_g [0:11];
  logic [7:0] exp_d [0:11];

  sync_fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4), .LOCK_PKT(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .grant(grant), .busy(busy)
  );

  sync_fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4), .LOCK_PKT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_data(req_data_b), .req_last(req_last_b),
    .req_ready(req_ready_b), .fifo_full(fifo_full_b), .fifo_wr_en(fifo_wr_en_b),
    .fifo_wr_data(fifo_wr_data_b), .grant(grant_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Producer 0 sends a 6-beat packet (C0..C5) while producer 3 offers one beat (3C).
  task automatic run_pkt(input bit sel, input int n);
    int   b;
    bit   p3_done;
    logic [3:0]  v, l, o_g, o_r;
    logic [31:0] d;
    logic        o_en;
    logic [7:0]  o_d;
    b = 0;
    p3_done = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      v = {!p3_done, 2'b00, (b < 6)};
      l = {1'b1, 2'b00, (b == 5)};
      d = {8'h3C, 16'h0000, 8'(8'hC0 + b)};
      if (sel) begin req_valid_b = v; req_last_b = l; req_data_b = d; end
      else     begin req_valid   = v; req_last   = l; req_data   = d; end
      #1;
      if (sel) begin o_en = fifo_wr_en_b; o_g = grant_b; o_d = fifo_wr_data_b; o_r = req_ready_b; end
      else     begin o_en = fifo_wr_en;   o_g = grant;   o_d = fifo_wr_data;   o_r = req_ready;   end
      chk($sformatf("pkt%0d_c%0d_grant", sel, c), o_g, exp_g[c]);
      chk($sformatf("pkt%0d_c%0d_wr_en", sel, c), o_en, exp_g[c] != 4'b0000);
      if (exp_g[c] != 4'b0000) chk($sformatf("pkt%0d_c%0d_data", sel, c), o_d, exp_d[c]);
      if (o_r[0] && v[0]) b++;
      if (o_r[3] && v[3]) p3_done = 1'b1;
    end
    @(negedge clk);
    if (sel) begin req_valid_b = '0; req_last_b = '0; req_data_b = '0; end
    else     begin req_valid   = '0; req_last   = '0; req_data   = '0; end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
    req_valid_b = '0; req_last_b = '0; req_data_b = '0; fifo_full_b = 1'b0;

    // reset state
    #2;
    chk("rst_grant", grant, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wr_en", fifo_wr_en, 1'b0);
    chk("rst_ready", req_ready, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    // producer 2 alone, 3 beats
    @(negedge clk);
    req_valid = 4'b0100; req_data[23:16] = 8'hA1; req_last = 4'b0000; #1;
    chk("p2_idle_grant", grant, 4'b0000);
    chk("p2_idle_wr_en", fifo_wr_en, 1'b0);
    @(negedge clk); #1;
    chk("p2_grant", grant, 4'b0100);
    chk("p2_busy", busy, 1'b1);
    chk("p2_b1_en", fifo_wr_en, 1'b1);
    chk("p2_b1_dat", fifo_wr_data, 8'hA1);
    @(negedge clk);
    req_data[23:16] = 8'hA2; #1;
    chk("p2_b2_en", fifo_wr_en, 1'b1);
    chk("p2_b2_dat", fifo_wr_data, 8'hA2);
    @(negedge clk);
    req_data[23:16] = 8'hA3; req_last = 4'b0100; #1;
    chk("p2_b3_en", fifo_wr_en, 1'b1);
    chk("p2_b3_dat", fifo_wr_data, 8'hA3);
    @(negedge clk);
    req_valid = '0; req_last = '0; #1;
    chk("p2_done_grant", grant, 4'b0000);
    chk("p2_done_busy", busy, 1'b0);

    // all four producers with back-to-back 1-beat packets
    pulse_reset();
    req_valid = 4'b1111; req_last = 4'b1111; req_data = 32'h13121110;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("rr%0d_bubble", k), fifo_wr_en, 1'b0);
      @(negedge clk); #1;
      chk($sformatf("rr%0d_grant", k), grant, 4'b0001 << (k % 4));
      chk($sformatf("rr%0d_en", k), fifo_wr_en, 1'b1);
      chk($sformatf("rr%0d_dat", k), fifo_wr_data, 8'h10 + 8'(k % 4));
      @(negedge clk);
    end
    req_valid = '0; req_last = '0; req_data = '0; #1;
    chk("rr_end_grant", grant, 4'b0000);

    // producer 1 streams 4 beats with a 2-cycle fifo_full stall after beat 2
    @(negedge clk);
    req_valid = 4'b0010; req_data[15:8] = 8'hB1; #1;
    chk("bp_idle_en", fifo_wr_en, 1'b0);
    @(negedge clk); #1;
    chk("bp_b1_grant", grant, 4'b0010);
    chk("bp_b1_dat", fifo_wr_data, 8'hB1);
    @(negedge clk);
    req_data[15:8] = 8'hB2; #1;
    chk("bp_b2_dat", fifo_wr_data, 8'hB2);
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      req_data[15:8] = 8'hB3; fifo_full = 1'b1; #1;
      chk($sformatf("bp_stall%0d_ready", s), req_ready, 4'b0000);
      chk($sformatf("bp_stall%0d_en", s), fifo_wr_en, 1'b0);
      chk($sformatf("bp_stall%0d_grant", s), grant, 4'b0010);
    end
    @(negedge clk);
    fifo_full = 1'b0; #1;
    chk("bp_b3_en", fifo_wr_en, 1'b1);
    chk("bp_b3_dat", fifo_wr_data, 8'hB3);
    @(negedge clk);
    req_data[15:8] = 8'hB4; req_last = 4'b0010; #1;
    chk("bp_b4_en", fifo_wr_en, 1'b1);
    chk("bp_b4_dat", fifo_wr_data, 8'hB4);
    @(negedge clk);
    req_valid = '0; req_last = '0; req_data = '0; #1;
    chk("bp_done_grant", grant, 4'b0000);

    // burst split: 4 beats from 0, one from 3, remaining 2 from 0
    exp_g[0] = 4'h0; exp_g[1] = 4'h1; exp_g[2] = 4'h1; exp_g[3] = 4'h1; exp_g[4] = 4'h1;
    exp_g[5] = 4'h0; exp_g[6] = 4'h8; exp_g[7] = 4'h0; exp_g[8] = 4'h1; exp_g[9] = 4'h1;
    exp_g[10] = 4'h0;
    exp_d[1] = 8'hC0; exp_d[2] = 8'hC1; exp_d[3] = 8'hC2; exp_d[4] = 8'hC3;
    exp_d[6] = 8'h3C; exp_d[8] = 8'hC4; exp_d[9] = 8'hC5;
    run_pkt(1'b1, 11);

    // packet lock: all 6 beats from 0, then 3
    pulse_reset();
    exp_g[0] = 4'h0;
    for (int c = 1; c <= 6; c++) begin
      exp_g[c] = 4'h1;
      exp_d[c] = 8'hC0 + 8'(c - 1);
    end
    exp_g[7] = 4'h0; exp_g[8] = 4'h8; exp_d[8] = 8'h3C; exp_g[9] = 4'h0;
    run_pkt(1'b0, 10);

    // mid-packet reset; owner 1 leaves last_owner pointing past 0 unless reset restores it
    @(negedge clk);
    req_valid = 4'b0010; req_last = 4'b0010; req_data[15:8] = 8'hE0; #1;
    chk("mr_idle_en", fifo_wr_en, 1'b0);
    @(negedge clk); #1;
    chk("mr_pre_grant", grant, 4'b0010);
    @(negedge clk);
    req_last = 4'b0000; req_data[15:8] = 8'hE1;
    @(negedge clk); #1;
    chk("mr_b1_dat", fifo_wr_data, 8'hE1);
    @(negedge clk);
    req_data[15:8] = 8'hE2; #1;
    chk("mr_b2_dat", fifo_wr_data, 8'hE2);
    @(negedge clk);
    rst_n = 1'b0; req_data[15:8] = 8'hE3; #1;
    chk("mr_rst_grant", grant, 4'b0000);
    chk("mr_rst_ready", req_ready, 4'b0000);
    chk("mr_rst_en", fifo_wr_en, 1'b0);
    chk("mr_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; req_valid = 4'b0101; req_last = 4'b0101; req_data = 32'h00F200F0; #1;
    chk("mr_post_idle_en", fifo_wr_en, 1'b0);
    @(negedge clk); #1;
    chk("mr_post_grant", grant, 4'b0001);
    chk("mr_post_dat", fifo_wr_data, 8'hF0);
    @(negedge clk);
    req_valid = '0; req_last = '0; req_data = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_wr_arbiter.md
# sync_fifo_wr_arbiter

Round-robin write arbiter that shares one synchronous FIFO's write port among `NUM_REQ` producers. Each producer presents beats on a valid/ready interface. The arbiter grants the port to one producer at a time and forwards that producer's beats as `fifo_wr_en`/`fifo_wr_data`. It honours FIFO backpressure and either keeps packets contiguous or splits them into bounded bursts. It sits directly in front of the team's `sync_fifo` write side.

## Interface
Parameters:
- `NUM_REQ`, 4, number of producers (2..16).
- `DATA_WIDTH`, 8, beat width; must match the FIFO.
- `MAX_BURST`, 4, maximum beats per grant when `LOCK_PKT`=0 (≥1).
- `LOCK_PKT`, 1. When 1, the grant is held until `req_last`. When 0, the grant is released at `req_last` or after `MAX_BURST` beats, whichever comes first.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NUM_REQ  per-producer beat valid.
- `req_data`  in  NUM_REQ*DATA_WIDTH  producer i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_last`  in  NUM_REQ  marks the last beat of a packet.
- `req_ready`  out  NUM_REQ  per-producer accept.
- `fifo_full`  in  1  FIFO full flag.
- `fifo_wr_en`  out  1  FIFO write strobe.
- `fifo_wr_data`  out  DATA_WIDTH  FIFO write data.
- `grant`  out  NUM_REQ  one-hot current owner; all zero when idle.
- `busy`  out  1  high in GRANT state.

## Operation
- A beat transfers from producer i when `req_valid[i] && req_ready[i]` in the same cycle.
- `req_ready[i]` = (state==GRANT) && `grant[i]` && !`fifo_full`. It is combinational from `fifo_full`.
- `fifo_wr_en` = OR over all i of (`req_valid[i] && req_ready[i]`).
- `fifo_wr_data` = owner's `req_data` slice, muxed combinationally. It is don't-care when `fifo_wr_en`=0, but must be driven with no X.
- State IDLE:
  - If any `req_valid` is high and `fifo_full`=0, select the first valid requester scanning upward from `last_owner+1`, modulo `NUM_REQ`.
  - Register that requester into `grant`, clear `beat_cnt`, and go to GRANT.
  - Otherwise remain in IDLE.
- State GRANT:
  - Each transfer increments `beat_cnt`.
  - Release on a transfer with `req_last`=1.
  - When `LOCK_PKT`=0, also release on a transfer that makes `beat_cnt`==`MAX_BURST`.
  - On release: store the owner in `last_owner`, clear `grant`, go to IDLE.
  - If the owner drops `req_valid` mid-packet, hold the grant indefinitely. There is no timeout.
- `beat_cnt` width is $clog2(MAX_BURST+1) and it saturates at `MAX_BURST`. It is unused when `LOCK_PKT`=1.
- `last_owner` resets to `NUM_REQ-1`, so requester 0 wins the first arbitration.
- Reset values: `grant`=0, `busy`=0, `fifo_wr_en`=0, `req_ready`=0, state IDLE, `beat_cnt`=0.

## Timing
- Arbitration latency: 1 cycle from `req_valid` rising in IDLE to `req_ready` able to go high.
- Throughput: one beat per cycle while granted and `fifo_full`=0.
- Each grant release costs one idle bubble cycle, so a release is always followed by IDLE.
- `fifo_full` asserting in GRANT stalls with the grant held. No beat is lost or duplicated.
- Simultaneous requests are served in round-robin order. With all producers continuously valid, grant order is 0,1,2,…,NUM_REQ-1,0.
- Mid-operation reset returns all state to reset values asynchronously. A partially sent packet is abandoned. FIFO contents are the FIFO's concern.
- `fifo_full` sampled in IDLE only gates the new grant. It adds no extra latency once full clears.

## Structure
- Package `sync_fifo_arb_pkg` holds:
  - the state enum (ARB_IDLE, ARB_GRANT);
  - a `clog2` helper function, if not already shared.
- Sub-module `rr_pick` is purely combinational:
  - inputs `req[NUM_REQ]` and `last[NUM_REQ]` (one-hot);
  - outputs one-hot `pick` and `any`;
  - it is instantiated once.
- The top level contains the state register, `beat_cnt`, `last_owner`, and the data/ready muxes.

## Test plan
- Reset, then producer 2 alone sends 3 beats 0xA1,0xA2,0xA3 (last on the 3rd). Required: `grant`=0b0100 one cycle after valid; the FIFO receives the 3 beats on 3 consecutive cycles; `grant`=0 after the last beat.
- All 4 producers hold 1-beat packets continuously. Required: FIFO write order is from producers 0,1,2,3,0, with one bubble between grants.
- Producer 1 streams 4 beats and `fifo_full` pulses high for 2 cycles after beat 2. Required: `req_ready[1]`=0 and `fifo_wr_en`=0 for those 2 cycles; beats 3 and 4 follow in order; the grant is retained throughout.
- `LOCK_PKT`=0, `MAX_BURST`=4, producer 0 sends a 6-beat packet while producer 3 is valid. Required: beats 1–4 from 0, then a grant to 3, then the remaining 2 beats from 0.
- `LOCK_PKT`=1, same stimulus. Required: all 6 beats from 0 contiguously before producer 3 is granted.
- `rst_n` is asserted after beat 2 of a 5-beat packet. Required: `grant`, `req_ready` and `fifo_wr_en` are 0 immediately. After release, the next arbitration grants requester 0 first.
